// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - instruction fetch queue with FWFT head, occupancy count and flush
// Optional IFQ_BYPASS_EN: an empty queue forwards in_* straight to out_* in the same cycle.
module inst_fetch_queue #(
    parameter int INST_WIDTH = 32,
    parameter int PC_WIDTH   = 32,
    parameter int DEPTH      = 8,
    parameter int AF_LEVEL   = DEPTH - 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [INST_WIDTH-1:0]    in_inst,
    input  logic [PC_WIDTH-1:0]      in_pc,
    input  logic                     in_fault,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INST_WIDTH-1:0]    out_inst,
    output logic [PC_WIDTH-1:0]      out_pc,
    output logic                     out_fault,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AF_CNT = (AW + 1)'(AF_LEVEL);

    logic [INST_WIDTH-1:0] inst_mem  [DEPTH];
    logic [PC_WIDTH-1:0]   pc_mem    [DEPTH];
    logic                  fault_mem [DEPTH];

    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        q_empty;
    logic        q_full;
    logic        bypass;
    logic        push;
    logic        pop;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign q_empty = (wr_ptr == rd_ptr);
    assign q_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign count       = wr_ptr - rd_ptr;
    assign empty       = q_empty;
    assign full        = q_full;
    assign almost_full = (count >= AF_CNT);
    assign in_ready    = !q_full;

`ifdef IFQ_BYPASS_EN
    assign bypass = in_valid && q_empty && !flush && !reset;
`else
    assign bypass = 1'b0;
`endif

    assign out_valid = !q_empty || bypass;

    always_comb begin
        out_inst  = '0;
        out_pc    = '0;
        out_fault = 1'b0;
        if (!q_empty) begin
            out_inst  = inst_mem[rd_ptr[AW-1:0]];
            out_pc    = pc_mem[rd_ptr[AW-1:0]];
            out_fault = fault_mem[rd_ptr[AW-1:0]];
        end else if (bypass) begin
            out_inst  = in_inst;
            out_pc    = in_pc;
            out_fault = in_fault;
        end
    end

    // A bypassed entry taken by decode in the same cycle is never stored.
    assign push = in_valid && in_ready && !(bypass && out_ready);
    assign pop  = !q_empty && out_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush && !reset) begin
            inst_mem[wr_ptr[AW-1:0]]  <= in_inst;
            pc_mem[wr_ptr[AW-1:0]]    <= in_pc;
            fault_mem[wr_ptr[AW-1:0]] <= in_fault;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - directed vector bench for inst_fetch_queue
module tb_inst_fetch_queue;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        in_fault;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_fault;
    logic [3:0]  count;
    logic        empty;
    logic        full;
    logic        almost_full;

    inst_fetch_queue #(.INST_WIDTH(32), .PC_WIDTH(32), .DEPTH(8), .AF_LEVEL(6)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
        .in_pc(in_pc), .in_fault(in_fault),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc(out_pc), .out_fault(out_fault),
        .count(count), .empty(empty), .full(full), .almost_full(almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        iv;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        flt;
        logic        ordy;
        logic [3:0]  e_count;
        logic        e_ov;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic        e_flt;
        logic        e_ir;
        logic        e_full;
        logic        e_af;
        logic        e_empty;
    } vec_t;

    vec_t        vecs[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_inst[$];
    logic [31:0] model_pc[$];
    int          n_in;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_pc     = '0;
        in_fault  = 1'b0;
        out_ready = 1'b0;
    endtask

    // Drive one cycle's inputs, clock, return to idle and let outputs settle.
    task automatic step(input logic fl, input logic iv, input logic [31:0] inst,
                        input logic [31:0] pc, input logic flt, input logic ordy);
        flush = fl; in_valid = iv; in_inst = inst; in_pc = pc; in_fault = flt; out_ready = ordy;
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic add(input logic iv, input logic [31:0] inst, input logic [31:0] pc,
                       input logic ordy, input int e_cnt, input logic e_ov,
                       input logic [31:0] e_inst, input logic [31:0] e_pc);
        vec_t v;
        v.fl = 1'b0; v.iv = iv; v.inst = inst; v.pc = pc; v.flt = 1'b0; v.ordy = ordy;
        v.e_count = 4'(e_cnt); v.e_ov = e_ov; v.e_inst = e_inst; v.e_pc = e_pc; v.e_flt = 1'b0;
        v.e_ir = (e_cnt < 8); v.e_full = (e_cnt == 8); v.e_af = (e_cnt >= 6); v.e_empty = (e_cnt == 0);
        vecs.push_back(v);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_af", almost_full, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_inst", out_inst, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_fault", out_fault, 0);

        // Fill to full, attempt a 9th push, then drain in order.
        for (int i = 0; i < 8; i++)
            add(1'b1, 32'h13 + i, 32'h1000 + 4 * i, 1'b0, i + 1, 1'b1, 32'h13, 32'h1000);
        add(1'b1, 32'h1B, 32'h1020, 1'b0, 8, 1'b1, 32'h13, 32'h1000);
        for (int k = 1; k <= 8; k++)
            add(1'b0, 32'h0, 32'h0, 1'b1, 8 - k, (k < 8),
                (k < 8) ? 32'h13 + k : 32'h0, (k < 8) ? 32'h1000 + 4 * k : 32'h0);

        foreach (vecs[j]) begin
            step(vecs[j].fl, vecs[j].iv, vecs[j].inst, vecs[j].pc, vecs[j].flt, vecs[j].ordy);
            chk($sformatf("v%0d_count", j), count, vecs[j].e_count);
            chk($sformatf("v%0d_out_valid", j), out_valid, vecs[j].e_ov);
            chk($sformatf("v%0d_out_inst", j), out_inst, vecs[j].e_inst);
            chk($sformatf("v%0d_out_pc", j), out_pc, vecs[j].e_pc);
            chk($sformatf("v%0d_out_fault", j), out_fault, vecs[j].e_flt);
            chk($sformatf("v%0d_in_ready", j), in_ready, vecs[j].e_ir);
            chk($sformatf("v%0d_full", j), full, vecs[j].e_full);
            chk($sformatf("v%0d_af", j), almost_full, vecs[j].e_af);
            chk($sformatf("v%0d_empty", j), empty, vecs[j].e_empty);
        end

        // Full queue: push and pop in the same cycle, only the pop happens.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'h50 + i, 32'h3000 + 4 * i, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h58, 32'h3020, 1'b0, 1'b1);
        chk("full_pushpop_count", count, 7);
        chk("full_pushpop_head", out_inst, 32'h51);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        chk("full_pushpop_drained", empty, 1);

        // Steady-state streaming at count 3 across the pointer wrap.
        n_in = 0;
        for (int i = 0; i < 3; i++) begin
            model_inst.push_back(32'h100 + n_in);
            model_pc.push_back(32'h4000 + 4 * n_in);
            step(1'b0, 1'b1, 32'h100 + n_in, 32'h4000 + 4 * n_in, 1'b0, 1'b0);
            n_in++;
        end
        for (int c = 0; c < 20; c++) begin
            chk($sformatf("stream%0d_head_inst", c), out_inst, model_inst[0]);
            chk($sformatf("stream%0d_head_pc", c), out_pc, model_pc[0]);
            model_inst.push_back(32'h100 + n_in);
            model_pc.push_back(32'h4000 + 4 * n_in);
            void'(model_inst.pop_front());
            void'(model_pc.pop_front());
            step(1'b0, 1'b1, 32'h100 + n_in, 32'h4000 + 4 * n_in, 1'b0, 1'b1);
            n_in++;
            chk($sformatf("stream%0d_count", c), count, 3);
        end
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("stream_drain%0d_inst", i), out_inst, model_inst[0]);
            void'(model_inst.pop_front());
            step(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        end
        chk("stream_empty", empty, 1);

        // Flush at count 5 with a push in the same cycle.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 32'h200 + i, 32'h5000 + 4 * i, 1'b0, 1'b0);
        chk("pre_flush_count", count, 5);
        step(1'b1, 1'b1, 32'hBAD, 32'h6000, 1'b0, 1'b1);
        chk("flush_count", count, 0);
        chk("flush_empty", empty, 1);
        chk("flush_out_valid", out_valid, 0);
        chk("flush_in_ready", in_ready, 1);
        step(1'b0, 1'b1, 32'h77, 32'h7000, 1'b0, 1'b0);
        chk("post_flush_count", count, 1);
        chk("post_flush_head", out_inst, 32'h77);
        step(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);

        // Fault flag travels with its entry.
        step(1'b0, 1'b1, 32'h300, 32'h2000, 1'b1, 1'b0);
        step(1'b0, 1'b1, 32'h301, 32'h2004, 1'b0, 1'b0);
        chk("fault_head_fault", out_fault, 1);
        chk("fault_head_pc", out_pc, 32'h2000);
        step(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        chk("fault_next_fault", out_fault, 0);
        chk("fault_next_pc", out_pc, 32'h2004);
        step(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        chk("fault_empty", empty, 1);

        // Reset mid-operation drops contents and any push that cycle.
        step(1'b0, 1'b1, 32'h400, 32'h8000, 1'b0, 1'b0);
        step(1'b0, 1'b1, 32'h401, 32'h8004, 1'b0, 1'b0);
        reset = 1'b1;
        step(1'b0, 1'b1, 32'h402, 32'h8008, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        chk("midrst_count", count, 0);
        chk("midrst_out_valid", out_valid, 0);

        // Empty queue with a simultaneous fetch and decode-ready.
        in_valid = 1'b1; in_inst = 32'hDEADBEEF; in_pc = 32'h9000; out_ready = 1'b1;
        #1;
`ifdef IFQ_BYPASS_EN
        chk("byp_same_out_valid", out_valid, 1);
        chk("byp_same_out_inst", out_inst, 32'hDEADBEEF);
`else
        chk("byp_same_out_valid", out_valid, 0);
        chk("byp_same_out_inst", out_inst, 0);
`endif
        @(posedge clk);
        #1;
        idle();
        #1;
`ifdef IFQ_BYPASS_EN
        chk("byp_next_count", count, 0);
        chk("byp_next_out_valid", out_valid, 0);
`else
        chk("byp_next_count", count, 1);
        chk("byp_next_out_valid", out_valid, 1);
        chk("byp_next_out_inst", out_inst, 32'hDEADBEEF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
